// File: rtl/pulsegate_burst.sv
// Purpose : emits an exact number of full-width clk pulses on gclk, optionally repeated
//           as several bursts with a programmable idle gap between them.
// Latency : start accepted at a posedge -> gate_en next cycle -> first gclk pulse one cycle later.
// Backpr. : none; start is ignored while busy, abort terminates immediately.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start, abort        launch / terminate a transaction (sampled on posedge clk)
//   count, gap, bursts  pulses per burst, idle cycles between bursts, number of bursts
//                       (captured on an accepted start; bursts==0 behaves as 1)
//   gclk                gated clock, clk AND gate_q
//   gate_en             posedge-registered gate request
//   busy, done          transaction in progress / one-cycle completion pulse
//   burst_idx           0-based index of the burst currently being produced
module pulsegate_burst #(
    parameter int CNT_W   = 8,
    parameter int GAP_W   = 8,
    parameter int BURST_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   count,
    input  logic [GAP_W-1:0]   gap,
    input  logic [BURST_W-1:0] bursts,
    output logic               gclk,
    output logic               gate_en,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] burst_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count_l;
    logic [GAP_W-1:0]     gap_l;
    logic [BURST_W-1:0]   last_l;   // index of the final burst
    logic [CNT_W:0]       pcnt;
    logic [GAP_W:0]       gcnt;
    logic                 gate_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count_l   <= '0;
            gap_l     <= '0;
            last_l    <= '0;
            pcnt      <= '0;
            gcnt      <= '0;
            gate_en   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            burst_idx <= '0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                state     <= IDLE;
                gate_en   <= 1'b0;
                busy      <= 1'b0;
                burst_idx <= '0;
                pcnt      <= '0;
                gcnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            count_l   <= count;
                            gap_l     <= gap;
                            // a burst count of zero is treated as a single burst
                            last_l    <= (bursts == '0) ? '0 : bursts - BURST_W'(1);
                            busy      <= 1'b1;
                            burst_idx <= '0;
                            gcnt      <= '0;
                            if (count == '0) begin
                                state <= FINISH;
                            end else begin
                                state   <= RUN;
                                gate_en <= 1'b1;
                                pcnt    <= (CNT_W+1)'(1);
                            end
                        end
                    end
                    RUN: begin
                        if (pcnt == {1'b0, count_l}) begin
                            if (burst_idx == last_l) begin
                                state   <= FINISH;
                                gate_en <= 1'b0;
                            end else if (gap_l == '0) begin
                                // zero gap: next burst follows back-to-back
                                pcnt      <= (CNT_W+1)'(1);
                                burst_idx <= burst_idx + BURST_W'(1);
                            end else begin
                                state   <= GAP;
                                gate_en <= 1'b0;
                                gcnt    <= (GAP_W+1)'(1);
                            end
                        end else begin
                            pcnt <= pcnt + (CNT_W+1)'(1);
                        end
                    end
                    GAP: begin
                        if (gcnt == {1'b0, gap_l}) begin
                            state     <= RUN;
                            gate_en   <= 1'b1;
                            pcnt      <= (CNT_W+1)'(1);
                            burst_idx <= burst_idx + BURST_W'(1);
                        end else begin
                            gcnt <= gcnt + (GAP_W+1)'(1);
                        end
                    end
                    FINISH: begin
                        // start is deliberately not looked at here
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Re-time the gate on the falling edge so it only changes while clk is low;
    // reset still clears it at once, even during a high phase.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_en;
        end
    end

    assign gclk = clk & gate_q;

endmodule
